// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side bundle between the pipeline control and the PC unit.
// master = pipeline control driving next-PC requests; slave = pc_unit.
interface pc_unit_if;
   logic        stall;
   logic [2:0]  npc_sel;
   logic        zero;
   logic        link;
   logic        ret;
   logic [25:0] imm;
   logic [31:0] target;
   logic [31:0] epc;
   logic        exc_req;
   logic        eret;
   logic [31:0] pc;
   logic [31:0] pcp4;
   logic        pending;
   logic        ras_empty;
   logic [31:0] ras_top;
   logic [15:0] ras_miss;

   modport master (
      output stall, npc_sel, zero, link, ret, imm, target, epc, exc_req, eret,
      input  pc, pcp4, pending, ras_empty, ras_top, ras_miss
   );

   modport slave (
      input  stall, npc_sel, zero, link, ret, imm, target, epc, exc_req, eret,
      output pc, pcp4, pending, ras_empty, ras_top, ras_miss
   );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: registered program counter for the MIPS fetch stage.
// Owns the PC register, stall hold and a latch for exception/eret redirects
// that arrive while stalled. Define PC_RAS_EN to build the optional
// return-address stack that predicts jr $ra and counts return mispredicts.
module pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00003000,
   parameter logic [31:0] EXC_VEC   = 32'h00004180,
   parameter int          RAS_DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   pc_unit_if.slave bus
);

   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,
      PEND_EXC  = 2'd1,
      PEND_ERET = 2'd2
   } pend_t;

   pend_t       pend_q, pend_d;
   logic [31:0] pc_q, pc_d, pcp4;
   logic        take_exc, take_eret, redirect, seq_ok;

   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   function automatic logic [31:0] beq_target(input logic [31:0] base,
                                              input logic [15:0] off);
      logic signed [31:0] disp;
      disp = $signed({{14{off[15]}}, off, 2'b00});
      return base + $unsigned(disp);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign pcp4 = pc_q + 32'd4;

   // Redirect arbitration, pending-latch next state and next-PC select
   always_comb begin
      take_exc  = (pend_q == PEND_EXC) || bus.exc_req;
      take_eret = !take_exc && ((pend_q == PEND_ERET) || bus.eret);
      redirect  = take_exc || take_eret;
      seq_ok    = !bus.stall && !redirect;

      // while stalled, the latch merges old and live requests by priority;
      // any unstalled edge applies the redirect and empties the latch
      pend_d = PEND_NONE;
      if (bus.stall) begin
         if (take_exc)
            pend_d = PEND_EXC;
         else if (take_eret)
            pend_d = PEND_ERET;
      end

      pc_d = pcp4;
      if (take_exc)
         pc_d = EXC_VEC;
      else if (take_eret)
         pc_d = align(bus.epc);
      else begin
         case (bus.npc_sel)
            3'b001:  if (bus.zero) pc_d = beq_target(pcp4, bus.imm[15:0]);
            3'b010:  pc_d = {pcp4[31:28], bus.imm, 2'b00};
            3'b100:  pc_d = align(bus.target);
            default: pc_d = pcp4;
         endcase
      end
   end

   // PC register and pending latch; reset discards any latched redirect
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         pend_q <= PEND_NONE;
      end else begin
         pend_q <= pend_d;
         if (!bus.stall)
            pc_q <= pc_d;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.pcp4    = pcp4;
   assign bus.pending = (pend_q != PEND_NONE);

`ifdef PC_RAS_EN
   localparam int          PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

   logic [31:0]   ras_mem [RAS_DEPTH];
   logic [PW-1:0] ras_ptr, top_idx;
   logic [PW:0]   ras_cnt;
   logic [15:0]   miss_q;
   logic          do_push, do_pop;
   logic          unused_bits;

   assign top_idx = ras_ptr - PW'(1);
   assign do_push = seq_ok && (bus.npc_sel == 3'b010) && bus.link;
   assign do_pop  = seq_ok && (bus.npc_sel == 3'b100) && bus.ret;

   // Stack pointer, occupancy and mispredict counter; a full push wraps
   // over the oldest entry while the count stays pinned at the depth
   always_ff @(posedge clk) begin
      if (reset) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
         miss_q  <= '0;
      end else if (do_push) begin
         ras_ptr <= ras_ptr + PW'(1);
         if (ras_cnt != FULL)
            ras_cnt <= ras_cnt + (PW+1)'(1);
      end else if (do_pop) begin
         if (ras_cnt != '0) begin
            ras_ptr <= top_idx;
            ras_cnt <= ras_cnt - (PW+1)'(1);
            if (ras_mem[top_idx] != align(bus.target))
               miss_q <= sat_inc(miss_q);
         end else begin
            miss_q <= sat_inc(miss_q);
         end
      end
   end

   // Return-address storage (data only, never reset)
   always_ff @(posedge clk) begin
      if (do_push)
         ras_mem[ras_ptr] <= pcp4;
   end

   assign bus.ras_empty = (ras_cnt == '0);
   assign bus.ras_top   = (ras_cnt == '0) ? 32'd0 : ras_mem[top_idx];
   assign bus.ras_miss  = miss_q;
   assign unused_bits   = ^{bus.target[1:0], bus.epc[1:0]};
`else
   logic unused_bits;

   assign bus.ras_empty = 1'b1;
   assign bus.ras_top   = 32'd0;
   assign bus.ras_miss  = 16'd0;
   assign unused_bits   = ^{bus.link, bus.ret, seq_ok, bus.target[1:0], bus.epc[1:0]};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit. A reference model computes the
// architectural next state from the next-PC rules; expected outputs are queued
// per edge and a monitor compares them against the DUT on the falling edge.
// Build with +define+PC_RAS_EN to exercise the return-address stack.
`timescale 1ns/1ps
module tb_pc_unit;
   localparam logic [31:0] RESET_PC = 32'h00003000;
   localparam logic [31:0] EXC_VEC  = 32'h00004180;
   localparam int          DEPTH    = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pcp4;
      logic        pending;
      logic        ras_empty;
      logic [31:0] ras_top;
      logic [15:0] ras_miss;
   } exp_t;

   logic clk;
   logic reset;
   pc_unit_if bus();

   pc_unit #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .RAS_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb[$];

   // reference model state
   logic [31:0] m_pc;
   int          m_pend;          // 0 none, 1 exception, 2 eret
   logic [31:0] m_ras[$];
   int          m_miss;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.pc        = m_pc;
      e.pcp4      = m_pc + 32'd4;
      e.pending   = (m_pend != 0);
`ifdef PC_RAS_EN
      e.ras_empty = (m_ras.size() == 0);
      e.ras_top   = (m_ras.size() == 0) ? 32'd0 : m_ras[$];
      e.ras_miss  = 16'(m_miss);
`else
      e.ras_empty = 1'b1;
      e.ras_top   = 32'd0;
      e.ras_miss  = 16'd0;
`endif
      return e;
   endfunction

   // architectural effect of one clock edge with the inputs now applied
   task automatic model_step();
      logic [31:0] p4;
      int          off;
      if (reset) begin
         m_pc = RESET_PC; m_pend = 0; m_ras.delete(); m_miss = 0;
      end else if (bus.stall) begin
         if (bus.exc_req) m_pend = 1;
         else if (bus.eret && m_pend == 0) m_pend = 2;
      end else begin
         p4 = m_pc + 32'd4;
         if (bus.exc_req || m_pend == 1)
            m_pc = EXC_VEC;
         else if (bus.eret || m_pend == 2)
            m_pc = bus.epc & ~32'd3;
         else begin
            case (bus.npc_sel)
               3'd1: begin
                  off  = $signed(bus.imm[15:0]);
                  m_pc = bus.zero ? p4 + 32'(off * 4) : p4;
               end
               3'd2: begin
                  m_pc = {p4[31:28], bus.imm, 2'b00};
`ifdef PC_RAS_EN
                  if (bus.link) begin
                     if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                     m_ras.push_back(p4);
                  end
`endif
               end
               3'd4: begin
                  m_pc = bus.target & ~32'd3;
`ifdef PC_RAS_EN
                  if (bus.ret) begin
                     if (m_ras.size() == 0) m_miss++;
                     else if (m_ras.pop_back() != m_pc) m_miss++;
                     if (m_miss > 16'hFFFF) m_miss = 16'hFFFF;
                  end
`endif
               end
               default: m_pc = p4;
            endcase
         end
         m_pend = 0;
      end
   endtask

   task automatic clr();
      reset = 1'b0;
      bus.stall = 1'b0; bus.npc_sel = 3'd0; bus.zero = 1'b0; bus.link = 1'b0;
      bus.ret = 1'b0; bus.imm = 26'd0; bus.target = 32'd0; bus.epc = 32'd0;
      bus.exc_req = 1'b0; bus.eret = 1'b0;
   endtask

   task automatic step();
      exp_t e;
      model_step();
      e = snapshot();
      @(posedge clk);
      sb.push_back(e);
      #1;
      clr();
   endtask

   task automatic jr_to(input logic [31:0] t, input logic r);
      bus.npc_sel = 3'd4; bus.target = t; bus.ret = r;
      step();
   endtask

   // monitor: compare every presented cycle against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc",        bus.pc,                e.pc);
            check("pcp4",      bus.pcp4,              e.pcp4);
            check("pending",   32'(bus.pending),      32'(e.pending));
            check("ras_empty", 32'(bus.ras_empty),    32'(e.ras_empty));
            check("ras_top",   bus.ras_top,           e.ras_top);
            check("ras_miss",  32'(bus.ras_miss),     32'(e.ras_miss));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, expected end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      m_pc = '0; m_pend = 0; m_miss = 0;
      clr();
      #1;
      // reset held two cycles, then sequential fetch
      reset = 1'b1; step();
      reset = 1'b1; step();
      step();
      step();

      // beq taken / not taken from 0x3010
      jr_to(32'h00003010, 1'b0);
      bus.npc_sel = 3'd1; bus.zero = 1'b1; bus.imm = 26'h000FFFE; step();
      jr_to(32'h00003010, 1'b0);
      bus.npc_sel = 3'd1; bus.zero = 1'b0; bus.imm = 26'h000FFFE; step();

      // j and jr
      jr_to(32'h00003000, 1'b0);
      bus.npc_sel = 3'd2; bus.imm = 26'h0000C40; step();
      jr_to(32'h00003207, 1'b0);

      // undefined select codes fall through to pc+4
      for (int c = 0; c < 8; c++) begin
         bus.npc_sel = 3'(c); bus.zero = 1'b1; bus.imm = 26'h0000C40;
         bus.target = 32'h00005000;
         if (c == 0 || c == 3 || c >= 5) step();
      end

      // stalled eret overwritten by stalled exception, applied on release
      bus.stall = 1'b1; bus.eret = 1'b1; bus.epc = 32'h00003050; step();
      bus.stall = 1'b1; bus.exc_req = 1'b1; step();
      bus.stall = 1'b1; bus.eret = 1'b1; bus.epc = 32'h00003060; step();
      step();
      // latched eret with live exception in the release cycle
      bus.stall = 1'b1; bus.eret = 1'b1; bus.epc = 32'h00003072; step();
      bus.exc_req = 1'b1; bus.npc_sel = 3'd2; bus.link = 1'b1; step();
      // latched eret applied; live jump ignored
      bus.stall = 1'b1; bus.eret = 1'b1; bus.epc = 32'h00003072; step();
      bus.npc_sel = 3'd2; bus.imm = 26'h0000C40; step();
      // reset discards a pending redirect
      bus.stall = 1'b1; bus.exc_req = 1'b1; step();
      reset = 1'b1; bus.stall = 1'b1; step();
      step();

`ifdef PC_RAS_EN
      // five jal pushes into a depth-4 stack, then returns
      reset = 1'b1; step();
      jr_to(32'h00003000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus.npc_sel = 3'd2; bus.link = 1'b1;
         bus.imm = 26'((32'h00003010 + 32'h10 * i) >> 2);
         step();
      end
      jr_to(32'h00003044, 1'b1);
      jr_to(32'h00003034, 1'b1);
      jr_to(32'h00003024, 1'b1);
      jr_to(32'h00003014, 1'b1);
      jr_to(32'h00003000, 1'b1);
      // mismatched return target
      bus.npc_sel = 3'd2; bus.link = 1'b1; bus.imm = 26'h0000C00; step();
      jr_to(32'h00003100, 1'b1);
      // push/pop ignored while stalled
      bus.stall = 1'b1; bus.npc_sel = 3'd2; bus.link = 1'b1; step();
      bus.stall = 1'b1; bus.npc_sel = 3'd4; bus.ret = 1'b1; step();
      // saturation of the mispredict counter
      reset = 1'b1; step();
      for (int i = 0; i < 65534 + 3; i++) begin
         bus.npc_sel = 3'd4; bus.ret = 1'b1; bus.target = 32'h00003000;
         step();
      end
      reset = 1'b1; step();
`endif

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         reset       = ($urandom_range(0, 59) == 0);
         bus.stall   = ($urandom_range(0, 3) == 0);
         bus.npc_sel = 3'($urandom_range(0, 7));
         bus.zero    = 1'($urandom);
         bus.link    = 1'($urandom);
         bus.ret     = 1'($urandom);
         bus.imm     = 26'($urandom);
         bus.epc     = $urandom;
         bus.exc_req = ($urandom_range(0, 11) == 0);
         bus.eret    = ($urandom_range(0, 9) == 0);
         if (m_ras.size() > 0 && $urandom_range(0, 1) == 1)
            bus.target = m_ras[$] | 32'($urandom_range(0, 3));
         else
            bus.target = $urandom;
         step();
      end

      repeat (2) @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
